mem_port_arbiter: RTL and testbench

//   Shares one single-ported memory between instruction fetch (req 0, read-only) and data access
//   (req 1, read/write). A round-robin FSM grants one requester at a time and holds the access for
//   MEM_LAT cycles. It drives the select of the 2:1 address/data muxes in front of the memory.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data.
// Holds each granted access for MEM_LAT cycles, then pulses done for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [DATA_W-1:0] rdata_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              last, last_n;
  logic              sel_n;
  logic [ADDR_W-1:0] addr_n;
  logic              we_n;
  logic [DATA_W-1:0] wdata_n;
  logic              gnt0_n, gnt1_n;
  logic              done0_n, done1_n;
  logic [DATA_W-1:0] rdata_n;
  logic              win;

  // On a tie the requester that did not finish last wins.
  assign win = (req0_i && req1_i) ? ~last : req1_i;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    last_n  = last;
    sel_n   = sel_o;
    addr_n  = mem_addr_o;
    we_n    = mem_we_o;
    wdata_n = mem_wdata_o;
    gnt0_n  = gnt0_o;
    gnt1_n  = gnt1_o;
    done0_n = done0_o;
    done1_n = done1_o;
    rdata_n = rdata_o;
    unique case (state)
      IDLE: begin
        if (req0_i || req1_i) begin
          sel_n   = win;
          addr_n  = win ? addr1_i : addr0_i;
          we_n    = win ? we1_i : 1'b0;
          wdata_n = win ? wdata1_i : '0;
          gnt0_n  = ~win;
          gnt1_n  = win;
          cnt_n   = CNT_INIT;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          rdata_n = mem_rdata_i;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
          we_n    = 1'b0;
          done0_n = ~sel_o;
          done1_n = sel_o;
          last_n  = sel_o;
          state_n = DONE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE: begin
        done0_n = 1'b0;
        done1_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= 1'b1;
      sel_o       <= 1'b0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      gnt0_o      <= 1'b0;
      gnt1_o      <= 1'b0;
      done0_o     <= 1'b0;
      done1_o     <= 1'b0;
      rdata_o     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      sel_o       <= sel_n;
      mem_addr_o  <= addr_n;
      mem_we_o    <= we_n;
      mem_wdata_o <= wdata_n;
      gnt0_o      <= gnt0_n;
      gnt1_o      <= gnt1_n;
      done0_o     <= done0_n;
      done1_o     <= done1_n;
      rdata_o     <= rdata_n;
    end
  end

  a_gnt_excl: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    !(gnt0_o && gnt1_o));

  a_done_excl: assert property (
    @(posedge clk_i) disable iff (!rst_i)
    !(done0_o && done1_o));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table
// plus hand-written tie, abort and late-drop sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic [31:0] addr0 = '0;
  logic        req1 = 1'b0;
  logic        we1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic [31:0] mrd = '0;
  logic        sel;
  logic [31:0] maddr;
  logic        mwe;
  logic [31:0] mwd;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata;

  int total = 0;
  int bad = 0;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_LAT(2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req0_i     (req0),
    .addr0_i    (addr0),
    .req1_i     (req1),
    .we1_i      (we1),
    .addr1_i    (addr1),
    .wdata1_i   (wdata1),
    .mem_rdata_i(mrd),
    .sel_o      (sel),
    .mem_addr_o (maddr),
    .mem_we_o   (mwe),
    .mem_wdata_o(mwd),
    .gnt0_o     (gnt0),
    .gnt1_o     (gnt1),
    .done0_o    (done0),
    .done1_o    (done1),
    .rdata_o    (rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, r0, r1, we1;
    logic [31:0] a0, a1, wd, mrd;
  } vin_t;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        g0, g1, d0, d1;
    logic [31:0] rd;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  vec_t  vt[11];
  vout_t got;
  int    ord[$];
  int    cyc[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  initial begin
    int viol, n, g1cnt;
    bit seen;
    vt[0]  = '{'{1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 32'hDEADBEEF, 32'h0},
               '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}};
    vt[1]  = vt[0];
    vt[2]  = '{'{1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80, 32'hDEADBEEF, 32'h0},
               '{1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}};
    vt[3]  = '{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0},
               '{1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0}};
    vt[4]  = '{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h12345678},
               '{1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0,
                 32'h12345678}};
    vt[5]  = '{'{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'hDEADBEEF, 32'h0},
               '{1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                 32'h12345678}};
    vt[6]  = '{'{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'hDEADBEEF, 32'h0},
               '{1'b1, 32'h80, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0,
                 32'h12345678}};
    vt[7]  = vt[6];
    vt[8]  = '{'{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'hDEADBEEF,
                 32'hAAAA5555},
               '{1'b1, 32'h80, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1,
                 32'hAAAA5555}};
    vt[9]  = '{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0},
               '{1'b1, 32'h80, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0,
                 32'hAAAA5555}};
    vt[10] = vt[9];

    for (int k = 0; k < 11; k++) begin
      rst    = vt[k].i.rst;
      req0   = vt[k].i.r0;
      req1   = vt[k].i.r1;
      we1    = vt[k].i.we1;
      addr0  = vt[k].i.a0;
      addr1  = vt[k].i.a1;
      wdata1 = vt[k].i.wd;
      mrd    = vt[k].i.mrd;
      tick();
      got = '{sel, maddr, mwe, mwd, gnt0, gnt1, done0, done1, rdata};
      chk($sformatf("vec%0d", k), 128'(got), 128'(vt[k].o));
    end

    // tie: both held for four accesses
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0;
    viol = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if ((gnt0 && gnt1) || (done0 && done1)) viol++;
      if (done0 || done1) begin
        ord.push_back(done1 ? 1 : 0);
        cyc.push_back(i);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_excl", 128'(viol), 128'(0));
    chk("tie_count", 128'(ord.size()), 128'(4));
    for (int k = 0; k < ord.size(); k++) begin
      chk($sformatf("tie_order%0d", k), 128'(ord[k]), 128'(k % 2));
      if (k == 0) chk("tie_first", 128'(cyc[0]), 128'(3));
      else chk($sformatf("tie_gap%0d", k),
               128'(cyc[k] - cyc[k-1]), 128'(4));
    end

    // abort: reset in 1st BUSY cycle of a write
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h100; wdata1 = 32'h55;
    tick();
    chk("abort_we_on", 128'({mwe, gnt1}), 128'(2'b11));
    rst = 1'b0; req1 = 1'b0;
    tick();
    chk("abort_rst", 128'({mwe, gnt1, done1}), 128'(3'b000));
    rst = 1'b1; req0 = 1'b1; addr0 = 32'h200;
    tick();
    chk("abort_idle", 128'({gnt0, done1, maddr}), 128'({2'b10, 32'h200}));
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (done1) seen = 1'b0;
      if (done0) seen = 1'b1;
    end
    chk("abort_next_done0", 128'(seen), 128'(1));
    req0 = 1'b0;
    tick();

    // late drop: req1 released in 2nd BUSY cycle
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h300; mrd = 32'h0BADF00D;
    tick();
    chk("late_gnt_c1", 128'({gnt1, sel, maddr}), 128'({2'b11, 32'h300}));
    tick();
    chk("late_gnt_c2", 128'(gnt1), 128'(1));
    req1 = 1'b0;
    tick();
    chk("late_done", 128'({done1, gnt1, rdata}),
        128'({2'b10, 32'h0BADF00D}));
    g1cnt = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt1) g1cnt++;
      if (done1) n++;
    end
    chk("late_no_regrant", 128'({g1cnt, n}), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
